// File: rtl/text_pixel_pipe.sv
// text_pixel_pipe: raster position -> text RAM/font ROM fetch -> attribute + pixel-on, fixed 5-clock latency.
module text_pixel_pipe #(
  parameter int COLS         = 60,
  parameter int ROWS         = 17,
  parameter int ADDR_W       = 10,
  parameter int XW           = 9,
  parameter int YW           = 9,
  parameter int BLINK_FRAMES = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [XW-1:0]     i_x,
  input  logic [YW-1:0]     i_y,
  input  logic              i_de,
  input  logic              i_hsync,
  input  logic              i_vsync,
  input  logic [6:0]        i_cursor_col,
  input  logic [4:0]        i_cursor_row,
  input  logic              i_cursor_en,
  output logic [ADDR_W-1:0] o_ram_addr,
  input  logic [15:0]       i_ram_data,
  output logic [11:0]       o_rom_addr,
  input  logic [7:0]        i_rom_data,
  output logic [7:0]        o_attr,
  output logic              o_active,
  output logic              o_de,
  output logic              o_hsync,
  output logic              o_vsync
);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  logic [XW-4:0] col;
  logic [YW-5:0] row;
  logic          hit, ok, vs_q, blink;
  logic [FW-1:0] frame;
  logic [4:0]    ctl [1:4];
  logic [2:0]    pix [1:4];
  logic [3:0]    line1, line2;
  logic [7:0]    attr3, attr4;
  assign col = i_x[XW-1:3];
  assign row = i_y[YW-1:4];
  assign hit = i_cursor_en && int'(col) == int'(i_cursor_col) && int'(row) == int'(i_cursor_row) && i_y[3:0] >= 4'd14;
  assign ok  = i_de && int'(col) < COLS && int'(row) < ROWS;
  // ctl carries {de, hsync, vsync, cursor_hit, in_range_and_de} down the pipe
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      for (int i = 1; i <= 4; i++) begin
        ctl[i] <= '0;
        pix[i] <= '0;
      end
      line1      <= '0;
      line2      <= '0;
      attr3      <= '0;
      attr4      <= '0;
      o_ram_addr <= '0;
      o_rom_addr <= '0;
      o_attr     <= '0;
      o_active   <= 1'b0;
      o_de       <= 1'b0;
      o_hsync    <= 1'b0;
      o_vsync    <= 1'b0;
      vs_q       <= 1'b0;
      frame      <= '0;
      blink      <= 1'b1;
    end else begin
      o_ram_addr <= ADDR_W'(int'(row) * COLS + int'(col));
      ctl[1]     <= {i_de, i_hsync, i_vsync, hit, ok};
      pix[1]     <= i_x[2:0];
      for (int i = 2; i <= 4; i++) begin
        ctl[i] <= ctl[i-1];
        pix[i] <= pix[i-1];
      end
      line1      <= i_y[3:0];
      line2      <= line1;
      o_rom_addr <= {i_ram_data[7:0], line2};
      attr3      <= i_ram_data[15:8];
      attr4      <= attr3;
      o_active   <= ctl[4][0] && (i_rom_data[~pix[4]] || (ctl[4][1] && blink));
      o_attr     <= ctl[4][0] ? attr4 : 8'h00;
      o_de       <= ctl[4][4];
      o_hsync    <= ctl[4][3];
      o_vsync    <= ctl[4][2];
      vs_q       <= i_vsync;
      if (i_vsync && !vs_q) begin
        frame <= (frame == FW'(BLINK_FRAMES - 1)) ? '0 : frame + 1'b1;
        blink <= (frame == FW'(BLINK_FRAMES - 1)) ? !blink : blink;
      end
    end
endmodule

// File: tb/tb_text_pixel_pipe.sv
// tb_text_pixel_pipe: directed dots with hand-derived expectations, checked by a due-cycle scoreboard.
module tb_text_pixel_pipe;
  logic        clk = 1'b0, rst = 1'b1;
  logic [8:0]  x = '0, y = '0;
  logic        de = 1'b0, hs = 1'b0, vs = 1'b0;
  logic [6:0]  cur_col = 7'd3;
  logic [4:0]  cur_row = 5'd2;
  logic        cur_en = 1'b0;
  logic [9:0]  ram_addr;
  logic [15:0] ram_data = '0;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic [7:0]  attr;
  logic        active, o_de, o_hs, o_vs;
  logic [15:0] ram [0:1023];
  logic [7:0]  rom [0:4095];
  int cyc = 0, n_chk = 0, n_fail = 0;
  typedef struct {int due; int kind; logic [15:0] val; string nm;} exp_t;
  exp_t q[$];

  text_pixel_pipe dut (
    .i_clk(clk), .i_rst(rst), .i_x(x), .i_y(y), .i_de(de), .i_hsync(hs), .i_vsync(vs),
    .i_cursor_col(cur_col), .i_cursor_row(cur_row), .i_cursor_en(cur_en),
    .o_ram_addr(ram_addr), .i_ram_data(ram_data), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .o_attr(attr), .o_active(active), .o_de(o_de), .o_hsync(o_hs), .o_vsync(o_vs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    ram_data <= ram[ram_addr];
    rom_data <= rom[rom_addr];
  end

  always @(negedge clk) begin
    logic [15:0] act;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].due == cyc) begin
        act = q[i].kind == 0 ? {4'h0, attr, active, o_de, o_hs, o_vs} :
              q[i].kind == 1 ? {6'h0, ram_addr} : {4'h0, rom_addr};
        n_chk++;
        if (act !== q[i].val) begin
          n_fail++;
          $display("FAIL %s cyc %0d: got %h expected %h", q[i].nm, cyc, act, q[i].val);
        end
        q.delete(i);
      end
  end

  task automatic push(input int due, input int kind, input logic [15:0] val, input string nm);
    q.push_back('{due, kind, val, nm});
  endtask

  task automatic dot(input int xi, input int yi, input logic d, input logic h, input logic v,
                     input logic [7:0] ea, input logic eact, input string nm);
    x = 9'(xi); y = 9'(yi); de = d; hs = h; vs = v;
    push(cyc + 5, 0, {4'h0, ea, eact, d, h, v}, nm);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) dot(0, 400, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "idle");
  endtask

  task automatic chk(input string nm, input int a, input int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  initial begin
    logic [0:7] glyph = 8'b0011_1100;
    bit vis;
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    for (int i = 0; i < 4096; i++) rom[i] = '0;
    ram[61]  = 16'h1E41;
    rom[12'h412] = 8'h3C;
    ram[123] = 16'h7000;
    for (int c = 0; c < 60; c++) begin
      ram[c] = {8'(c * 4 + 3), 8'(8'h80 + c)};
      rom[{8'(8'h80 + c), 4'd5}] = 8'h80;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(6);
    // glyph fetch: 'A' at row 1 col 1, line 2
    push(cyc + 1, 1, 16'd61, "ram_addr");
    push(cyc + 3, 2, 16'h0412, "rom_addr");
    for (int i = 0; i < 8; i++) dot(8 + i, 18, 1'b1, 1'b0, 1'b0, 8'h1E, glyph[i], "glyph");
    idle(2);
    // sync alignment: isolated one-cycle pulses
    dot(8, 300, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, "hsync_pulse");
    idle(2);
    dot(8, 300, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, "vsync_pulse");
    idle(2);
    dot(8, 18, 1'b1, 1'b0, 1'b0, 8'h1E, 1'b0, "de_pulse");
    idle(2);
    // full line at y=5: attr per column, only leftmost dot of each cell lit
    for (int xi = 0; xi < 480; xi++)
      dot(xi, 5, 1'b1, 1'b0, 1'b0, 8'((xi / 8) * 4 + 3), xi % 8 == 0, "line_scan");
    // out of range
    dot(480, 5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "col60");
    dot(500, 5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "col62");
    dot(8, 272, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "row17");
    dot(10, 18, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "de_low");
    idle(6);
    // asynchronous reset mid-line
    x = 9'd10; y = 9'd18; de = 1'b1; hs = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    chk("pre_reset_de", int'(o_de), 1);
    rst = 1'b1;
    #1;
    chk("rst_de", int'(o_de), 0);
    chk("rst_hsync", int'(o_hs), 0);
    chk("rst_attr", int'(attr), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_ram_addr", int'(ram_addr), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    hs = 1'b0;
    for (int k = 1; k <= 4; k++) push(cyc + k, 0, 16'h0000, "post_reset_zero");
    dot(10, 18, 1'b1, 1'b0, 1'b0, 8'h1E, 1'b1, "post_reset_first");
    idle(6);
    // cursor blink at (3,2); frame k = after k vsync rising edges
    cur_en = 1'b1;
    for (int f = 0; f <= 33; f++) begin
      if (f > 0) begin
        dot(0, 400, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, "frame_vsync");
        idle(1);
      end
      if (f == 33) cur_en = 1'b0;
      vis = (f < 16 || f >= 32) && cur_en;
      if (f == 0 || f == 15 || f == 16 || f == 31 || f == 32 || f == 33) begin
        for (int yi = 45; yi <= 47; yi++)
          for (int xi = 24; xi < 32; xi++)
            dot(xi, yi, 1'b1, 1'b0, 1'b0, 8'h70, vis && yi >= 46, "cursor");
        idle(6);
      end
    end
    repeat (8) @(posedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/text_pixel_pipe.md
Name: text_pixel_pipe

Overview:
- Text-mode pixel generator sitting directly upstream of the CGA colour stage.
- Converts raster position from the LCD timing generator into an 8-bit irgb/irgb attribute byte plus a "pixel on" bit, which the colour stage turns into RGB565.
- Fetches character/attribute words from text RAM and glyph rows from an 8x16 font ROM, both synchronous with 1-cycle read latency.
- Handles cursor blink and keeps the delayed sync/enable signals aligned with the pixel data.

Parameters:
COLS, 60, text columns per row
ROWS, 17, text rows per screen
ADDR_W, 10, text RAM address width (must satisfy 2^ADDR_W >= COLS*ROWS)
XW, 9, width of horizontal position input
YW, 9, width of vertical position input
BLINK_FRAMES, 16, frames per cursor blink half-period

Ports:
i_clk  input  1  pixel clock
i_rst  input  1  reset, asynchronous, active-high
i_x  input  XW  pixel column of current dot
i_y  input  YW  pixel line of current dot
i_de  input  1  display enable for current dot
i_hsync  input  1  horizontal sync, passed through delayed
i_vsync  input  1  vertical sync, passed through delayed; active-high pulse
i_cursor_col  input  7  cursor text column
i_cursor_row  input  5  cursor text row
i_cursor_en  input  1  cursor enable
o_ram_addr  output  ADDR_W  text RAM read address
i_ram_data  input  16  [15:8] attribute byte, [7:0] character code; valid 1 cycle after address
o_rom_addr  output  12  font ROM address {char[7:0], line[3:0]}
i_rom_data  input  8  glyph row; bit 7 is leftmost pixel; valid 1 cycle after address
o_attr  output  8  attribute to colour stage (back irgb [7:4], fore irgb [3:0])
o_active  output  1  1 = foreground pixel
o_de  output  1  i_de delayed to match pixel
o_hsync  output  1  i_hsync delayed to match pixel
o_vsync  output  1  i_vsync delayed to match pixel

Behaviour:
- Decode: col = i_x[XW-1:3], row = i_y[YW-1:4], line = i_y[3:0], bit = i_x[2:0].
- Fixed latency of 5 clocks. The dot presented at cycle n appears on o_attr/o_active/o_de/o_hsync/o_vsync at n+5.
- Stage 1 (n+1): o_ram_addr = row*COLS + col, registered. Multiply is width-truncated to ADDR_W. col, row, line, bit, de, sync, cursor-hit and in-range flags are carried alongside.
- Stage 2 (n+2): i_ram_data valid.
- Stage 3 (n+3): o_rom_addr = {char, line} registered; attribute latched.
- Stage 4 (n+4): i_rom_data valid.
- Stage 5 (n+5): o_active = i_rom_data[7-bit] OR cursor_on; o_attr = latched attribute.
- Out-of-range (col >= COLS or row >= ROWS) or de=0: o_active=0 and o_attr=8'h00 at the output stage. The RAM address is still driven but is don't-care.
- Cursor:
  - cursor_hit = i_cursor_en && col==i_cursor_col && row==i_cursor_row && line>=14.
  - cursor_on = cursor_hit && blink_phase.
  - Cursor forces o_active=1 but never changes o_attr.
- Blink:
  - Frame counter increments on each rising edge of i_vsync (edge detected with a registered copy).
  - On reaching BLINK_FRAMES-1, the counter wraps to 0 and blink_phase toggles.
  - blink_phase resets to 1, so the cursor is visible first.
- Reset (asynchronous, any time, including mid-line): all pipeline registers, o_ram_addr, o_rom_addr, o_attr, o_active, o_de, o_hsync, o_vsync, frame counter and vsync edge register go to 0; blink_phase goes to 1.
  - After reset deasserts, the first valid output is 5 cycles later. Outputs in between are 0 (de=0).
- No stalls or back-pressure. The block processes one dot per clock continuously.
- i_ram_data and i_rom_data are sampled exactly at n+2 and n+4; there is no other handshake.

Test Plan:
- Reset: assert i_rst mid-frame -> all outputs 0 immediately (asynchronous); first non-zero o_de appears exactly 5 clocks after i_de=1 with reset released.
- Glyph fetch: RAM model at addr 61 holds 16'h1E41 ('A', blue back/yellow fore); i_x=8..15, i_y=18 -> o_ram_addr=61; o_rom_addr=12'h412; ROM row 8'b0011_1100 -> o_active 0,0,1,1,1,1,0,0 with o_attr=8'h1E, each 5 clocks after its dot.
- Sync alignment: 1-cycle pulse on i_hsync at cycle n -> o_hsync pulse at exactly n+5; same check for i_vsync and i_de.
- Out-of-range: i_x=480 (col 60) with i_de=1 -> o_active=0, o_attr=8'h00, o_de=1; and i_de=0 inside the text area -> o_attr=8'h00.
- Cursor blink: cursor at (3,2), en=1; glyph row all zero.
  - Frames 0-15: lines 46-47 of columns 24-31 give o_active=1 and line 45 gives 0.
  - Frames 16-31: o_active=0 on those lines.
  - Frame 32: o_active=1 again.
  - en=0 -> cursor never shown.
- Back-to-back characters: continuous scan of a full 480-dot line with distinct RAM contents per column -> o_attr changes exactly at each 8-dot boundary with no skipped or repeated character.
